// File: rtl/fft_stage_sched_pkg.sv
// Shared FFT package: transform size defaults, scheduler latency, scheduler
// state type, plus the complex sample type and fixed-point constants used
// by the datapath.
package fft_stage_sched_pkg;

  // Default transform size and derived stage count / address width.
  localparam int FFT_N_DEF       = 16;
  localparam int FFT_LOG2N_DEF   = $clog2(FFT_N_DEF);

  // Default data RAM / twiddle ROM read latency and butterfly latency.
  localparam int FFT_MEM_LAT_DEF = 1;
  localparam int FFT_BFU_LAT_DEF = 4;

  // Issue-to-write-back latency of one butterfly.
  localparam int FFT_PIPE        = FFT_MEM_LAT_DEF + FFT_BFU_LAT_DEF;

  // Fixed-point format of the datapath samples (Q1.15).
  localparam int FX_WIDTH        = 16;
  localparam int FX_FRAC         = 15;

  typedef struct packed {
    logic signed [FX_WIDTH-1:0] re;
    logic signed [FX_WIDTH-1:0] im;
  } complex_t;

  // Scheduler states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/fft_stage_sched_addr_gen.sv
// fft_addr_gen: combinational radix-2 DIT address mapper.
// For stage s and butterfly k it inserts a zero bit at position s of k to
// form the A address, sets that bit for B, and scales the in-group position
// up to the twiddle ROM index. Kept standalone so a reference model can reuse it.
module fft_addr_gen
  import fft_stage_sched_pkg::*;
#(
  parameter int LOG2N = FFT_LOG2N_DEF,
  parameter int SW    = $clog2(LOG2N)
) (
  input  logic [SW-1:0]    s,
  input  logic [LOG2N-2:0] k,
  output logic [LOG2N-1:0] a,
  output logic [LOG2N-1:0] b,
  output logic [LOG2N-2:0] tw
);

  localparam int KW = LOG2N - 1;

  logic [KW-1:0]    mask_s;   // half-1: selects the position inside a group
  logic [KW-1:0]    pos_s;    // k & (half-1)
  logic [KW-1:0]    hi_s;     // (k >> s) << s
  logic [LOG2N-1:0] half_s;   // 1 << s
  logic [SW-1:0]    tw_sh_s;  // LOG2N-1-s

  // Map (s, k) onto the butterfly's A/B addresses and twiddle index.
  always_comb begin
    // When s = LOG2N-1 the shifted one falls off the top and the mask becomes all ones.
    mask_s  = (KW'(1'b1) << s) - KW'(1'b1);
    pos_s   = k & mask_s;
    hi_s    = k & ~mask_s;
    half_s  = LOG2N'(1'b1) << s;
    a       = {hi_s, 1'b0} | {1'b0, pos_s};
    b       = a | half_s;
    tw_sh_s = SW'(LOG2N - 1) - s;
    tw      = pos_s << tw_sh_s;
  end

endmodule

// File: rtl/fft_stage_sched.sv
// fft_stage_sched: sequencer for an in-place radix-2 DIT FFT on one shared
// butterfly. Issues one butterfly per cycle per stage, drains the
// memory+butterfly pipeline between stages so the next stage never reads a
// location before it is written, and replays the read addresses PIPE
// cycles later as write-back strobes.
// Optional build macro: FFT_STAGE_SCHED_INVERSE_EN adds the inverse input
// and tw_conj output for IFFT twiddle conjugation.
module fft_stage_sched
  import fft_stage_sched_pkg::*;
#(
  parameter int N       = FFT_N_DEF,
  parameter int LOG2N   = $clog2(N),
  parameter int MEM_LAT = FFT_MEM_LAT_DEF,
  parameter int BFU_LAT = FFT_BFU_LAT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
`ifdef FFT_STAGE_SCHED_INVERSE_EN
  input  logic                     inverse,
  output logic                     tw_conj,
`endif
  output logic                     busy,
  output logic                     done,
  output logic                     rd_en,
  output logic [LOG2N-1:0]         rd_addr_a,
  output logic [LOG2N-1:0]         rd_addr_b,
  output logic [LOG2N-2:0]         tw_addr,
  output logic                     bfu_en,
  output logic                     wr_en,
  output logic [LOG2N-1:0]         wr_addr_a,
  output logic [LOG2N-1:0]         wr_addr_b,
  output logic [$clog2(LOG2N)-1:0] stage
);

  localparam int SW   = $clog2(LOG2N);
  localparam int KW   = LOG2N - 1;
  localparam int PIPE = MEM_LAT + BFU_LAT;
  localparam int CW   = $clog2(PIPE + 1);

  localparam logic [KW-1:0] K_LAST   = KW'(N / 2 - 1);
  localparam logic [SW-1:0] S_LAST   = SW'(LOG2N - 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(PIPE);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  sched_state_e     state_r, state_nxt_s;
  logic [SW-1:0]    s_r, s_nxt_s;
  logic [KW-1:0]    k_r, k_nxt_s;
  logic [CW-1:0]    cnt_r, cnt_nxt_s;

  logic [LOG2N-1:0] gen_a_s, gen_b_s;
  logic [KW-1:0]    gen_tw_s;

  logic             busy_r, done_r, rd_en_r, bfu_en_r;
  logic [LOG2N-1:0] rd_addr_a_r, rd_addr_b_r;
  logic [KW-1:0]    tw_addr_r;
  logic [SW-1:0]    stage_r;

  // Write-back delay line: entry i holds the read issued i+1 cycles ago.
  logic             dl_en_r [PIPE];
  logic [LOG2N-1:0] dl_a_r  [PIPE];
  logic [LOG2N-1:0] dl_b_r  [PIPE];

`ifdef FFT_STAGE_SCHED_INVERSE_EN
  logic inv_r, inv_nxt_s, tw_conj_r;
`endif

  // Addresses are generated from the next (s, k) so they register alongside rd_en.
  fft_addr_gen #(
    .LOG2N (LOG2N),
    .SW    (SW)
  ) u_addr_gen (
    .s  (s_nxt_s),
    .k  (k_nxt_s),
    .a  (gen_a_s),
    .b  (gen_b_s),
    .tw (gen_tw_s)
  );

  // Next-state logic: stage/butterfly counters and the inter-stage drain count.
  always_comb begin
    state_nxt_s = state_r;
    s_nxt_s     = s_r;
    k_nxt_s     = k_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_ISSUE;
          s_nxt_s     = {SW{1'b0}};
          k_nxt_s     = {KW{1'b0}};
          cnt_nxt_s   = {CW{1'b0}};
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // K_LAST is all ones, so the increment wraps k back to 0 for the next stage.
        k_nxt_s = k_r + KW'(1'b1);
        if (k_r == K_LAST) begin
          state_nxt_s = ST_DRAIN;
          cnt_nxt_s   = CNT_LOAD;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        // Leaving on the last count puts the next read right after the stage's last write.
        if (cnt_r == CNT_ONE) begin
          cnt_nxt_s = {CW{1'b0}};
          if (s_r == S_LAST) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_ISSUE;
            s_nxt_s     = s_r + SW'(1'b1);
            k_nxt_s     = {KW{1'b0}};
          end
        end else begin
          cnt_nxt_s = cnt_r - CW'(1'b1);
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

`ifdef FFT_STAGE_SCHED_INVERSE_EN
  // Capture inverse only when a start is accepted; hold it for the whole run.
  always_comb begin
    if ((state_r == ST_IDLE) && start) begin
      inv_nxt_s = inverse;
    end else begin
      inv_nxt_s = inv_r;
    end
  end
`endif

  // FSM state and registered control/address outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      s_r         <= {SW{1'b0}};
      k_r         <= {KW{1'b0}};
      cnt_r       <= {CW{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      rd_en_r     <= 1'b0;
      bfu_en_r    <= 1'b0;
      rd_addr_a_r <= {LOG2N{1'b0}};
      rd_addr_b_r <= {LOG2N{1'b0}};
      tw_addr_r   <= {KW{1'b0}};
      stage_r     <= {SW{1'b0}};
`ifdef FFT_STAGE_SCHED_INVERSE_EN
      inv_r       <= 1'b0;
      tw_conj_r   <= 1'b0;
`endif
    end else begin
      state_r  <= state_nxt_s;
      s_r      <= s_nxt_s;
      k_r      <= k_nxt_s;
      cnt_r    <= cnt_nxt_s;
      busy_r   <= (state_nxt_s == ST_ISSUE) || (state_nxt_s == ST_DRAIN);
      bfu_en_r <= (state_nxt_s == ST_ISSUE) || (state_nxt_s == ST_DRAIN);
      done_r   <= (state_nxt_s == ST_DONE);
      rd_en_r  <= (state_nxt_s == ST_ISSUE);
      stage_r  <= s_nxt_s;
      // Addresses are zero whenever no read is issued, so the delay line carries zeros too.
      if (state_nxt_s == ST_ISSUE) begin
        rd_addr_a_r <= gen_a_s;
        rd_addr_b_r <= gen_b_s;
        tw_addr_r   <= gen_tw_s;
      end else begin
        rd_addr_a_r <= {LOG2N{1'b0}};
        rd_addr_b_r <= {LOG2N{1'b0}};
        tw_addr_r   <= {KW{1'b0}};
      end
`ifdef FFT_STAGE_SCHED_INVERSE_EN
      inv_r     <= inv_nxt_s;
      tw_conj_r <= (state_nxt_s == ST_ISSUE) && inv_nxt_s;
`endif
    end
  end

  // Shift issued reads down the delay line so they emerge as write-backs PIPE cycles later.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE; i++) begin
        dl_en_r[i] <= 1'b0;
        dl_a_r[i]  <= {LOG2N{1'b0}};
        dl_b_r[i]  <= {LOG2N{1'b0}};
      end
    end else begin
      dl_en_r[0] <= rd_en_r;
      dl_a_r[0]  <= rd_addr_a_r;
      dl_b_r[0]  <= rd_addr_b_r;
      for (int i = 1; i < PIPE; i++) begin
        dl_en_r[i] <= dl_en_r[i-1];
        dl_a_r[i]  <= dl_a_r[i-1];
        dl_b_r[i]  <= dl_b_r[i-1];
      end
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign rd_en     = rd_en_r;
  assign rd_addr_a = rd_addr_a_r;
  assign rd_addr_b = rd_addr_b_r;
  assign tw_addr   = tw_addr_r;
  assign bfu_en    = bfu_en_r;
  assign wr_en     = dl_en_r[PIPE-1];
  assign wr_addr_a = dl_a_r[PIPE-1];
  assign wr_addr_b = dl_b_r[PIPE-1];
  assign stage     = stage_r;
`ifdef FFT_STAGE_SCHED_INVERSE_EN
  assign tw_conj   = tw_conj_r;
`endif

endmodule

// File: tb/tb_fft_stage_sched.sv
// Directed bench for fft_stage_sched with the default N=16, PIPE=5.
// Cycle t of a run is the cycle after the t-th rising edge from the start cycle
// (start is driven during cycle 0). Outputs are sampled on the falling edge.
module tb_fft_stage_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy, done, rd_en, bfu_en, wr_en;
  logic [3:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [2:0] tw_addr;
  logic [1:0] stage;
`ifdef FFT_STAGE_SCHED_INVERSE_EN
  logic       inverse = 1'b0;
  logic       tw_conj;
`endif

  fft_stage_sched dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
`ifdef FFT_STAGE_SCHED_INVERSE_EN
    .inverse   (inverse),
    .tw_conj   (tw_conj),
`endif
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .tw_addr   (tw_addr),
    .bfu_en    (bfu_en),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b),
    .stage     (stage)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { int a; int b; int st; } rd_rec_t;
  rd_rec_t rd_q[$];

  int wr_cnt, done_cnt;
  int cov [4];
  bit rd_seen [4];
  bit inv_exp = 1'b0;

  // Hand-computed reads: relative cycle, A, B, twiddle.
  int hv_rel [9] = '{1, 8, 14, 15, 21, 32, 40, 45, 47};
  int hv_a   [9] = '{0, 14, 0, 1, 13, 9, 0, 5, 7};
  int hv_b   [9] = '{1, 15, 2, 3, 15, 13, 8, 13, 15};
  int hv_tw  [9] = '{0, 0, 0, 4, 4, 2, 0, 5, 7};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Stage s issues in relative cycles 1+13s .. 8+13s.
  function automatic bit exp_rd(input int rel);
    int s, r;
    if (rel < 1) return 1'b0;
    s = (rel - 1) / 13;
    r = (rel - 1) % 13;
    return (s < 4) && (r < 8);
  endfunction

  task automatic new_run();
    wr_cnt   = 0;
    done_cnt = 0;
    rd_q.delete();
    for (int i = 0; i < 4; i++) begin
      cov[i]     = 0;
      rd_seen[i] = 1'b0;
    end
  endtask

  // Check one cycle against the expected schedule, then drive inputs for it.
  task automatic cyc(input int rel, input logic st, input logic rs, input bit zchk);
    int s, k;
    rd_rec_t e;
    @(negedge clk);
    if (zchk) begin
      check_eq("all_zero", {busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
                            bfu_en, wr_en, wr_addr_a, wr_addr_b, stage}, 32'd0);
    end
    check_eq("busy",   busy,   (rel >= 1) && (rel <= 52));
    check_eq("done",   done,   rel == 53);
    check_eq("bfu_en", bfu_en, (rel >= 1) && (rel <= 52));
    check_eq("rd_en",  rd_en,  exp_rd(rel));
    check_eq("wr_en",  wr_en,  exp_rd(rel - 5));
`ifdef FFT_STAGE_SCHED_INVERSE_EN
    check_eq("tw_conj", tw_conj, exp_rd(rel) && inv_exp);
`endif
    if (done) done_cnt++;
    if (rd_en && exp_rd(rel)) begin
      s = (rel - 1) / 13;
      k = (rel - 1) % 13;
      check_eq("stage", stage, s);
      check_eq("b_minus_a", 32'(rd_addr_b) - 32'(rd_addr_a), 32'(1) << s);
      check_eq("a_bit_s", (32'(rd_addr_a) >> s) & 32'd1, 32'd0);
      for (int i = 0; i < 9; i++) begin
        if (rel == hv_rel[i]) begin
          check_eq($sformatf("hv_a_s%0d_k%0d", s, k), rd_addr_a, hv_a[i]);
          check_eq($sformatf("hv_b_s%0d_k%0d", s, k), rd_addr_b, hv_b[i]);
          check_eq($sformatf("hv_tw_s%0d_k%0d", s, k), tw_addr, hv_tw[i]);
        end
      end
      cov[s] = cov[s] | (1 << rd_addr_a) | (1 << rd_addr_b);
      rd_seen[s] = 1'b1;
      rd_q.push_back('{a: int'(rd_addr_a), b: int'(rd_addr_b), st: s});
    end
    if (wr_en) begin
      wr_cnt++;
      check_eq("wr_has_pending_read", rd_q.size() > 0, 1'b1);
      if (rd_q.size() > 0) begin
        e = rd_q.pop_front();
        check_eq("wr_addr_a", wr_addr_a, e.a);
        check_eq("wr_addr_b", wr_addr_b, e.b);
        if (e.st < 3) check_eq("stage_hazard", rd_seen[e.st + 1], 1'b0);
      end
    end
    if (rs) begin
      rd_q.delete();
      for (int i = 0; i < 4; i++) rd_seen[i] = 1'b0;
    end
    start = st;
    rst   = rs;
  endtask

  task automatic end_of_run(input string tag);
    check_eq({tag, "_writes"}, wr_cnt, 32);
    check_eq({tag, "_done_pulses"}, done_cnt, 1);
    check_eq({tag, "_queue_empty"}, rd_q.size(), 0);
    for (int i = 0; i < 4; i++) check_eq($sformatf("%s_cover_s%0d", tag, i), cov[i], 32'hFFFF);
  endtask

  initial begin
    new_run();
    // Reset, then one idle cycle.
    cyc(-100, 1'b0, 1'b1, 1'b1);
    cyc(-100, 1'b0, 1'b0, 1'b1);
    cyc(-100, 1'b0, 1'b0, 1'b1);

    // Full transform; a second start in cycle 20 must be ignored.
    for (int r = 0; r <= 60; r++) cyc(r, (r == 0) || (r == 20), 1'b0, 1'b0);
    end_of_run("run1");

    // Reset (with a simultaneous start) in cycle 30, restart in cycle 35.
    new_run();
    for (int r = 0; r <= 30; r++) cyc(r, (r == 0) || (r == 30), r == 30, 1'b0);
    new_run();
    for (int g = 31; g <= 90; g++) cyc((g < 35) ? -100 : g - 35, g == 35, 1'b0, g == 31);
    end_of_run("run2");

`ifdef FFT_STAGE_SCHED_INVERSE_EN
    // Inverse run: inverse only high in the start cycle, must be held.
    new_run();
    inv_exp = 1'b1;
    for (int r = 0; r <= 56; r++) begin
      cyc(r, r == 0, 1'b0, 1'b0);
      inverse = (r == 0);
    end
    end_of_run("inv1");
    // Forward run: inverse low at start, toggled high afterwards.
    new_run();
    inv_exp = 1'b0;
    for (int r = 0; r <= 56; r++) begin
      cyc(r, r == 0, 1'b0, 1'b0);
      inverse = (r != 0);
    end
    end_of_run("inv0");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fft_stage_sched.md
Name: fft_stage_sched

Overview:
- Sequencer for one radix-2 DIT in-place FFT using a single shared butterfly unit.
- The butterfly has 4 register stages behind an `en` input.
- For every stage and butterfly, the block issues:
  - the A/B read addresses into the data RAM,
  - the twiddle ROM address,
  - delayed write-back addresses and strobes that line up with the butterfly outputs.
- Sits between the top-level FFT control (start/done) and the data RAM, twiddle ROM and butterfly.

Parameters:
- N, 16, FFT points; power of two, at least 4.
- LOG2N, $clog2(N), number of stages; also the address width.
- MEM_LAT, 1, read latency of the data RAM and twiddle ROM, in cycles.
- BFU_LAT, 4, butterfly input-to-output latency, in cycles.

Ports:
- clk  in  1  clock; the single clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to run a transform; ignored unless in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the last write-back has been committed.
- rd_en  out  1  data RAM and twiddle ROM read strobe.
- rd_addr_a  out  LOG2N  RAM address of butterfly input A.
- rd_addr_b  out  LOG2N  RAM address of butterfly input B.
- tw_addr  out  LOG2N-1  twiddle ROM index, 0..N/2-1.
- bfu_en  out  1  butterfly pipeline advance.
- wr_en  out  1  RAM write strobe for both butterfly outputs.
- wr_addr_a  out  LOG2N  write address for butterfly output A.
- wr_addr_b  out  LOG2N  write address for butterfly output B.
- stage  out  $clog2(LOG2N)  current stage index, for debug.

Behaviour:
- All outputs are registered.
- Reset values: all outputs are 0, the state is IDLE and the delay line is cleared.

States:
- IDLE: waits for start.
  - start=1 → ISSUE, with s=0 and k=0.
- ISSUE: one butterfly per cycle, with rd_en=1.
  - At k=N/2-1 → DRAIN, with the drain counter loaded to PIPE=MEM_LAT+BFU_LAT.
- DRAIN: rd_en=0 while the counter decrements.
  - When the counter hits 0 and s<LOG2N-1: s++, k=0, → ISSUE.
  - When the counter hits 0 and s=LOG2N-1: → DONE.
- DONE: done=1 and busy=0 for one cycle, then → IDLE.

Address generation for stage s and butterfly k:
- half = 1<<s
- pos = k & (half-1)
- grp = k>>s
- a = (grp<<(s+1)) | pos
- b = a + half
- tw = pos << (LOG2N-1-s)

Pipeline and delay line:
- bfu_en is 1 in ISSUE and DRAIN, and 0 otherwise.
- The wr_en, wr_addr_a and wr_addr_b lanes are the rd_en and read addresses delayed by PIPE cycles through a shift register.
- A write for an issue in cycle t appears in cycle t+PIPE.

Stage hazard:
- The next stage's first read occurs only in the cycle after the previous stage's last write.
- No read-during-write forwarding is required from the RAM.

Timing with defaults (N=16, PIPE=5), taking the start cycle as 0:
- Stage s issues in cycles 1+13s through 8+13s.
- The final write occurs in cycle 52.
- done pulses in cycle 53; busy is high for cycles 1–52.

Boundary and corner rules:
- start while busy or in DONE is ignored and is not queued.
- rst mid-transform returns to IDLE in the next cycle, drops every output to 0 and discards pending writes.
- The block does not emit done after a mid-transform reset.
- If start and rst are high in the same cycle, rst wins.
- Counter wrap: k is LOG2N-1 bits wide and wraps to 0 at the stage boundary.

Optional Feature:
- Macro: FFT_STAGE_SCHED_INVERSE_EN.
- When defined:
  - add input port `inverse` (1 bit), sampled when start is accepted and held for the run;
  - add output `tw_conj` (1 bit), equal to the held inverse value and aligned with rd_en (0 in IDLE, 0 at reset);
  - downstream conjugates the twiddle for an IFFT.
- When not defined: neither port exists and the behaviour is otherwise identical.

Decomposition:
- Shared FFT package:
  - the N and LOG2N defaults,
  - a PIPE latency constant,
  - an enum type for the scheduler states.
- The existing complex_t and the fixed-point constants stay in that package untouched.
- Sub-module fft_addr_gen: a combinational (s, k) → (a, b, tw) mapper, reusable by a future verification model.
- The delay line stays inline.

Test Plan:
- Reset, then start at cycle 0 → busy=1 in cycles 1–52, done pulses only in cycle 53, busy=0 in cycle 53.
- Stage 0, k=0 → rd_addr_a=0, rd_addr_b=1, tw_addr=0. Stage 1, k=1 → 1, 3, 4.
- Stage 2, k=5 → 9, 13, 2. Stage 3, k=5 → 5, 13, 5.
- Every rd_en in cycle t is matched by wr_en in cycle t+5 with identical addresses; exactly 32 writes in total; no read in a cycle ≤ that of its stage's last write.
- start pulsed in cycle 20 while busy → ignored; done is still in cycle 53 and there is exactly one done pulse.
- rst asserted in cycle 30 → all outputs 0 in cycle 31; no wr_en afterwards; a new start in cycle 35 gives done in cycle 88.
- With FFT_STAGE_SCHED_INVERSE_EN: inverse=1 at start → tw_conj=1 on every rd_en cycle; a following run with inverse=0 → tw_conj=0.
